axis_crc_checker_mw: RTL and testbench



---
 rtl/axis_crc_checker_mw.sv | 125 ++++++++++++
 tb/tb_axis_crc_checker_mw.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_crc_checker_mw.sv
// AXI-Stream pass-through that checks a trailing CRC field per frame and flags bad frames in tuser.
// Define AXIS_CRC_STATS_EN to add saturating frame_cnt / err_cnt outputs.
module axis_crc_checker_mw #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CRC_WIDTH  = 8,
  parameter logic [CRC_WIDTH-1:0] POLY = CRC_WIDTH'(8'h07),
  parameter logic [CRC_WIDTH-1:0] INIT = '0
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
`ifdef AXIS_CRC_STATS_EN
  output logic [31:0]             frame_cnt,
  output logic [31:0]             err_cnt,
`endif
  output logic                    m_axis_tuser
);

  localparam int unsigned KeepW = DATA_WIDTH / 8;

  typedef enum logic {StIdle, StInFrame} state_e;

  state_e                  r_state, w_state_next;
  logic [CRC_WIDTH-1:0]    r_crc, w_crc_next;
  logic                    r_keep_err, w_keep_err_next;
  logic                    r_valid;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [KeepW-1:0]        r_keep;
  logic                    r_last, r_user;
  logic                    w_accept, w_frame_bad;

  function automatic logic [CRC_WIDTH-1:0] crc_byte(input logic [CRC_WIDTH-1:0] crc,
                                                    input logic [7:0] b);
    logic [CRC_WIDTH-1:0] c;
    c = crc ^ (CRC_WIDTH'(b) << (CRC_WIDTH - 8));
    for (int i = 0; i < 8; i++) begin
      c = c[CRC_WIDTH-1] ? ((c << 1) ^ POLY) : (c << 1);
    end
    return c;
  endfunction

  assign s_axis_tready = !r_valid || m_axis_tready;
  assign w_accept      = s_axis_tvalid && s_axis_tready;

  // Lanes fold lane 0 first; lanes with tkeep=0 never touch the CRC.
  always_comb begin
    w_crc_next = (r_state == StIdle) ? INIT : r_crc;
    for (int l = 0; l < KeepW; l++) begin
      if (s_axis_tkeep[l]) w_crc_next = crc_byte(w_crc_next, s_axis_tdata[8*l +: 8]);
    end
  end

  assign w_keep_err_next = r_keep_err ||
                           (s_axis_tlast ? !(|s_axis_tkeep) : !(&s_axis_tkeep));
  assign w_frame_bad     = (w_crc_next != '0) || w_keep_err_next;

  always_comb begin
    w_state_next = r_state;
    if (w_accept) w_state_next = s_axis_tlast ? StIdle : StInFrame;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state    <= StIdle;
      r_crc      <= INIT;
      r_keep_err <= 1'b0;
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_keep     <= '0;
      r_last     <= 1'b0;
      r_user     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_valid <= 1'b1;
        r_data  <= s_axis_tdata;
        r_keep  <= s_axis_tkeep;
        r_last  <= s_axis_tlast;
        r_user  <= s_axis_tlast && w_frame_bad;
        if (s_axis_tlast) begin
          r_crc      <= INIT;
          r_keep_err <= 1'b0;
        end else begin
          r_crc      <= w_crc_next;
          r_keep_err <= w_keep_err_next;
        end
      end else if (m_axis_tready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign m_axis_tvalid = r_valid;
  assign m_axis_tdata  = r_data;
  assign m_axis_tkeep  = r_keep;
  assign m_axis_tlast  = r_last;
  assign m_axis_tuser  = r_user;

`ifdef AXIS_CRC_STATS_EN
  logic [31:0] r_frame_cnt, r_err_cnt;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else if (w_accept && s_axis_tlast) begin
      if (r_frame_cnt != 32'hFFFF_FFFF) r_frame_cnt <= r_frame_cnt + 32'd1;
      if (w_frame_bad && (r_err_cnt != 32'hFFFF_FFFF)) r_err_cnt <= r_err_cnt + 32'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign err_cnt   = r_err_cnt;
`endif

endmodule

// File: tb/tb_axis_crc_checker_mw.sv
// Scoreboard bench for axis_crc_checker_mw: an 8-bit and a 16-bit instance with CRC-8/0x07.
module tb_axis_crc_checker_mw;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  logic [7:0]  s8_tdata, m8_tdata;
  logic        s8_tkeep, m8_tkeep, s8_tvalid, s8_tready, s8_tlast;
  logic        m8_tvalid, m8_tready, m8_tlast, m8_tuser;
  logic [15:0] s16_tdata, m16_tdata;
  logic [1:0]  s16_tkeep, m16_tkeep;
  logic        s16_tvalid, s16_tready, s16_tlast;
  logic        m16_tvalid, m16_tready, m16_tlast, m16_tuser;
`ifdef AXIS_CRC_STATS_EN
  logic [31:0] fc8, ec8, fc16, ec16;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int stalls8  = 0;
  int fr8 = 0, er8 = 0;
  logic rnd8 = 1'b0;
  logic [63:0] q8[$];
  logic [63:0] q16[$];

  axis_crc_checker_mw u_dut8 (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s8_tdata), .s_axis_tkeep(s8_tkeep), .s_axis_tvalid(s8_tvalid),
    .s_axis_tready(s8_tready), .s_axis_tlast(s8_tlast),
    .m_axis_tdata(m8_tdata), .m_axis_tkeep(m8_tkeep), .m_axis_tvalid(m8_tvalid),
    .m_axis_tready(m8_tready), .m_axis_tlast(m8_tlast),
`ifdef AXIS_CRC_STATS_EN
    .frame_cnt(fc8), .err_cnt(ec8),
`endif
    .m_axis_tuser(m8_tuser)
  );

  axis_crc_checker_mw #(.DATA_WIDTH(16)) u_dut16 (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s16_tdata), .s_axis_tkeep(s16_tkeep), .s_axis_tvalid(s16_tvalid),
    .s_axis_tready(s16_tready), .s_axis_tlast(s16_tlast),
    .m_axis_tdata(m16_tdata), .m_axis_tkeep(m16_tkeep), .m_axis_tvalid(m16_tvalid),
    .m_axis_tready(m16_tready), .m_axis_tlast(m16_tlast),
`ifdef AXIS_CRC_STATS_EN
    .frame_cnt(fc16), .err_cnt(ec16),
`endif
    .m_axis_tuser(m16_tuser)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bit-serial CRC-8 reference, polynomial x^8+x^2+x+1.
  function automatic logic [7:0] crc8_ref(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    r = c ^ b;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  task automatic send8(input logic [7:0] d, input logic last, input logic bad);
    int n;
    logic ok;
    s8_tdata = d; s8_tkeep = 1'b1; s8_tlast = last; s8_tvalid = 1'b1;
    n = 0;
    do begin
      @(negedge aclk);
      ok = s8_tready;
      if (!ok) stalls8++;
      @(posedge aclk); #1;
      n++;
    end while (!ok && n < 1000);
    if (!ok) check("s8_timeout", 64'(ok), 64'd1);
    else begin
      q8.push_back(64'({d, 1'b1, last, last & bad}));
      if (last) begin fr8++; if (bad) er8++; end
    end
    s8_tvalid = 1'b0;
  endtask

  task automatic send16(input logic [15:0] d, input logic [1:0] k, input logic last,
                        input logic bad);
    int n;
    logic ok;
    s16_tdata = d; s16_tkeep = k; s16_tlast = last; s16_tvalid = 1'b1;
    n = 0;
    do begin
      @(negedge aclk);
      ok = s16_tready;
      @(posedge aclk); #1;
      n++;
    end while (!ok && n < 1000);
    if (!ok) check("s16_timeout", 64'(ok), 64'd1);
    else q16.push_back(64'({d, k, last, last & bad}));
    s16_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q8.size() + q16.size()) != 0 && n < 2000) begin
      @(posedge aclk); #1;
      n++;
    end
    check("drain", 64'(q8.size() + q16.size()), 64'd0);
  endtask

  task automatic frame8_str();
    for (int i = 0; i < 9; i++) send8(8'h31 + 8'(i), 1'b0, 1'b0);
    send8(8'hF4, 1'b1, 1'b0);
  endtask

  // Output monitors: a transfer happens at the posedge after a negedge seeing valid && ready.
  initial forever begin
    @(negedge aclk);
    if (aresetn && m8_tvalid && m8_tready) begin
      if (q8.size() == 0) check("out8_extra", 64'(q8.size()), 64'd1);
      else check("out8", 64'({m8_tdata, m8_tkeep, m8_tlast, m8_tuser}), q8.pop_front());
    end
  end

  initial forever begin
    @(negedge aclk);
    if (aresetn && m16_tvalid && m16_tready) begin
      if (q16.size() == 0) check("out16_extra", 64'(q16.size()), 64'd1);
      else check("out16", 64'({m16_tdata, m16_tkeep, m16_tlast, m16_tuser}), q16.pop_front());
    end
  end

  initial begin
    m8_tready = 1'b1;
    forever begin
      @(posedge aclk); #1;
      m8_tready = rnd8 ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    logic [7:0] c, b;
    int len;
    aresetn = 1'b0;
    s8_tdata = '0; s8_tkeep = '0; s8_tvalid = 1'b0; s8_tlast = 1'b0;
    s16_tdata = '0; s16_tkeep = '0; s16_tvalid = 1'b0; s16_tlast = 1'b0;
    m16_tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    check("rst8", 64'({m8_tvalid, m8_tdata, m8_tkeep, m8_tlast, m8_tuser}), 64'd0);
    check("rst16", 64'({m16_tvalid, m16_tdata, m16_tkeep, m16_tlast, m16_tuser}), 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;

    // 8-bit: good, bad, single-byte, back-to-back check-string frames.
    send8(8'h01, 1'b0, 1'b0); send8(8'h07, 1'b1, 1'b0);
    send8(8'h01, 1'b0, 1'b0); send8(8'h06, 1'b1, 1'b1);
    send8(8'h00, 1'b1, 1'b0);
    send8(8'h05, 1'b1, 1'b1);
    stalls8 = 0;
    frame8_str();
    frame8_str();
    check("b2b_stalls", 64'(stalls8), 64'd0);

    // 8-bit: 100 random good frames under 50% output backpressure.
    rnd8 = 1'b1;
    for (int f = 0; f < 100; f++) begin
      c = 8'h00;
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        b = 8'($urandom);
        c = crc8_ref(c, b);
        send8(b, 1'b0, 1'b0);
      end
      send8(c, 1'b1, 1'b0);
    end
    rnd8 = 1'b0;

    // 16-bit: partial last beat, corrupted CRC, keep errors, full-width frame.
    send16(16'h0201, 2'b11, 1'b0, 1'b0); send16(16'h001B, 2'b01, 1'b1, 1'b0);
    send16(16'h0201, 2'b11, 1'b0, 1'b0); send16(16'h001A, 2'b01, 1'b1, 1'b1);
    send16(16'h0201, 2'b01, 1'b0, 1'b0); send16(16'h001B, 2'b01, 1'b1, 1'b1);
    send16(16'h0701, 2'b11, 1'b0, 1'b0); send16(16'h0000, 2'b00, 1'b1, 1'b1);
    send16(16'h3231, 2'b11, 1'b0, 1'b0); send16(16'h3433, 2'b11, 1'b0, 1'b0);
    send16(16'h3635, 2'b11, 1'b0, 1'b0); send16(16'h3837, 2'b11, 1'b0, 1'b0);
    send16(16'hF439, 2'b11, 1'b1, 1'b0);
    drain();

    // Reset in the middle of a 16-bit frame, then a good frame.
    send16(16'h0201, 2'b11, 1'b0, 1'b0);
    drain();
    @(posedge aclk); #1;
    aresetn = 1'b0;
    #3;
    check("rst16_mid", 64'({m16_tvalid, m16_tdata, m16_tkeep, m16_tlast, m16_tuser}), 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    fr8 = 0; er8 = 0;
    @(posedge aclk); #1;
    check("crc_init16", 64'(u_dut16.r_crc), 64'd0);
    check("valid16_post_rst", 64'(m16_tvalid), 64'd0);
    send16(16'h0201, 2'b11, 1'b0, 1'b0); send16(16'h001B, 2'b01, 1'b1, 1'b0);
    drain();

`ifdef AXIS_CRC_STATS_EN
    for (int i = 0; i < 3; i++) begin
      send8(8'h01, 1'b0, 1'b0); send8(8'h07, 1'b1, 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      send8(8'h01, 1'b0, 1'b0); send8(8'h06, 1'b1, 1'b1);
    end
    drain();
    check("frame_cnt8", 64'(fc8), 64'(fr8));
    check("err_cnt8", 64'(ec8), 64'(er8));
    check("frame_cnt16", 64'(fc16), 64'd1);
    check("err_cnt16", 64'(ec16), 64'd0);
    force u_dut8.r_frame_cnt = 32'hFFFF_FFFF;
    force u_dut8.r_err_cnt   = 32'hFFFF_FFFF;
    @(posedge aclk); #1;
    release u_dut8.r_frame_cnt;
    release u_dut8.r_err_cnt;
    send8(8'h01, 1'b0, 1'b0); send8(8'h06, 1'b1, 1'b1);
    drain();
    check("frame_cnt8_sat", 64'(fc8), 64'hFFFF_FFFF);
    check("err_cnt8_sat", 64'(ec8), 64'hFFFF_FFFF);
`endif

    repeat (3) @(posedge aclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
